// File: rtl/serv_dbus_resp_pkg.sv
// serv_dbus_resp_pkg
// Shared constants for the SERV data-bus responder.
//   CNT_W   : width of the wait counter; it must hold WAIT_CYCLES (0..15).
//   state_e : responder FSM states.
package serv_dbus_resp_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_e;

endpackage

// File: rtl/serv_dbus_ram.sv
// serv_dbus_ram
// DEPTH x 32 word memory with per-byte write enables and a registered read port.
// The array has no reset, so its contents survive reset. The read register does
// reset to 0, and it only changes on a read strobe.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (read register only)
//   addr  : word index
//   wdata : write data
//   we    : byte-lane write enables, bit i -> wdata[8i+7:8i]
//   re    : read strobe; loads rdata with mem[addr]
//   rdata : registered read data
module serv_dbus_ram
    import serv_dbus_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    we,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/serv_dbus_resp.sv
// serv_dbus_resp
// Wishbone-style data-bus responder for the SERV core. It accepts one request,
// waits WAIT_CYCLES, and then completes it with a single-cycle ack.
// Optional macro: SERV_DBUS_RESP_ERR_EN. When it is defined, a word address
// at or beyond DEPTH gets an err pulse instead of an ack. When it is not
// defined, such an address wraps modulo DEPTH.
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_wb_adr       : byte address; adr[1:0] is ignored
//   i_wb_dat       : store data
//   i_wb_sel       : byte-lane enables for writes
//   i_wb_we        : 1 = write, 0 = read
//   i_wb_cyc       : request valid, held until ack/err
//   o_wb_rdt       : read data, held until the next completed read
//   o_wb_ack       : one-cycle completion pulse
//   o_wb_err       : one-cycle error pulse
module serv_dbus_resp
    import serv_dbus_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      adr_q, dat_q;
    logic [3:0]       sel_q;
    logic             we_q;
    logic             ack_q;

    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        req_we;
    logic        go;
    logic        range_err;
    logic [3:0]  ram_we;
    logic        ram_re;

    // With WAIT_CYCLES=0 the memory access happens on the accepting edge,
    // before the latch is loaded, so the live bus inputs are used in IDLE.
    always_comb begin
        req_adr = (state_q == StIdle) ? i_wb_adr : adr_q;
        req_dat = (state_q == StIdle) ? i_wb_dat : dat_q;
        req_sel = (state_q == StIdle) ? i_wb_sel : sel_q;
        req_we  = (state_q == StIdle) ? i_wb_we  : we_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_wb_cyc) begin
                    cnt_d = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAck;
                        go      = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!i_wb_cyc) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StAck;
                        go      = 1'b1;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef SERV_DBUS_RESP_ERR_EN
    logic err_q;
    logic unused_adr;
    assign range_err  = (req_adr[31:2] >= 30'(DEPTH));
    assign unused_adr = ^req_adr[1:0];
`else
    logic unused_adr;
    assign range_err  = 1'b0;
    assign unused_adr = ^{req_adr[31:AW+2], req_adr[1:0]};
`endif

    // The memory is touched only on the edge that enters ACK.
    assign ram_we = {4{go & req_we & ~range_err}} & req_sel;
    assign ram_re = go & ~req_we & ~range_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= go & ~range_err;
        end
    end

`ifdef SERV_DBUS_RESP_ERR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= go & range_err;
        end
    end
    assign o_wb_err = err_q;
`else
    assign o_wb_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
        end else if (state_q == StIdle && i_wb_cyc) begin
            adr_q <= i_wb_adr;
            dat_q <= i_wb_dat;
            sel_q <= i_wb_sel;
            we_q  <= i_wb_we;
        end
    end

    serv_dbus_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .addr  (req_adr[AW+1:2]),
        .wdata (req_dat),
        .we    (ram_we),
        .re    (ram_re),
        .rdata (o_wb_rdt)
    );

    assign o_wb_ack = ack_q;

endmodule

// File: tb/tb_serv_dbus_resp.sv
module tb_serv_dbus_resp;

`ifdef SERV_DBUS_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic [2:0]  cyc = '0;
    logic [2:0]  ack, err;
    logic [2:0][31:0] rdt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=0, instance 2: WAIT_CYCLES=3
    serv_dbus_resp #(.DEPTH(256), .WAIT_CYCLES(1)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
        .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(cyc[0]),
        .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0])
    );
    serv_dbus_resp #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
        .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(cyc[1]),
        .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1])
    );
    serv_dbus_resp #(.DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
        .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(cyc[2]),
        .o_wb_rdt(rdt[2]), .o_wb_ack(ack[2]), .o_wb_err(err[2])
    );

    function automatic int wc(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Runs one complete transaction on instance k; call #1 after a rising edge.
    task automatic txn(input int k, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we, input logic exp_err,
                       input logic [31:0] exp_rdt, input string name);
        int   lat;
        logic a, e;
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; cyc[k] = 1'b1;
        lat = 0; a = 1'b0; e = 1'b0;
        while (!(a || e) && lat < 32) begin
            @(posedge clk); #1;
            lat++;
            a = ack[k];
            e = err[k];
        end
        cyc[k] = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(wc(k) + 1));
        check({name, " ack"}, 32'(a), 32'(!exp_err));
        check({name, " err"}, 32'(e), 32'(exp_err));
        check({name, " rdt"}, rdt[k], exp_rdt);
        @(posedge clk); #1;
        check({name, " pulse width"}, 32'({ack[k], err[k]}), 32'd0);
    endtask

    // Transaction-level reference for instance 0.
    logic [31:0] mdl_mem [256];
    logic [31:0] mdl_rdt = '0;

    task automatic model_txn(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we,
                             output logic exp_err, output logic [31:0] exp_rdt);
        int unsigned word, idx;
        word = adr / 4;
        exp_err = ERR_EN && (word >= 256);
        if (!exp_err) begin
            idx = word % 256;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mdl_mem[idx][8*b +: 8] = dat[8*b +: 8];
            end else begin
                mdl_rdt = mdl_mem[idx];
            end
        end
        exp_rdt = mdl_rdt;
    endtask

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        err;
        logic [31:0] rdt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic        e_err;
        logic [31:0] e_rdt;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        we;

        tbl[0]  = '{32'h10,   32'hAABBCCDD, 4'hF, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{32'h10,   32'h0,        4'hF, 1'b0, 1'b0, 32'hAABBCCDD};
        tbl[2]  = '{32'h10,   32'h11223344, 4'h5, 1'b1, 1'b0, 32'hAABBCCDD};
        tbl[3]  = '{32'h10,   32'h0,        4'hF, 1'b0, 1'b0, 32'hAA22CC44};
        tbl[4]  = '{32'h10,   32'hDEADBEEF, 4'h0, 1'b1, 1'b0, 32'hAA22CC44};
        tbl[5]  = '{32'h13,   32'h0,        4'h0, 1'b0, 1'b0, 32'hAA22CC44};
        tbl[6]  = '{32'h0,    32'h01020304, 4'hF, 1'b1, 1'b0, 32'hAA22CC44};
        tbl[7]  = '{32'h400,  32'hCAFEF00D, 4'hF, 1'b1, ERR_EN, 32'hAA22CC44};
        tbl[8]  = '{32'h0,    32'h0,        4'hF, 1'b0, 1'b0,
                    ERR_EN ? 32'h01020304 : 32'hCAFEF00D};
        tbl[9]  = '{32'h400,  32'h0,        4'hF, 1'b0, ERR_EN,
                    ERR_EN ? 32'h01020304 : 32'hCAFEF00D};
        tbl[10] = '{32'h1000, 32'h0,        4'hF, 1'b0, ERR_EN,
                    ERR_EN ? 32'h01020304 : 32'hCAFEF00D};

        // Reset
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ack[%0d]", k), 32'(ack[k]), 32'd0);
            check($sformatf("reset err[%0d]", k), 32'(err[k]), 32'd0);
            check($sformatf("reset rdt[%0d]", k), rdt[k], 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Give every word of instance 0 a known value
        for (int i = 0; i < 256; i++) begin
            dat = $urandom;
            model_txn(32'(i * 4), dat, 4'hF, 1'b1, e_err, e_rdt);
            txn(0, 32'(i * 4), dat, 4'hF, 1'b1, e_err, e_rdt, $sformatf("init %0d", i));
        end

        // Directed table
        for (int i = 0; i < 11; i++) begin
            model_txn(tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].we, e_err, e_rdt);
            txn(0, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].we, tbl[i].err, tbl[i].rdt,
                $sformatf("vec %0d", i));
        end

        // Random against the reference model
        for (int i = 0; i < 200; i++) begin
            adr = $urandom;
            if ($urandom_range(3) != 0) adr = adr & 32'h0000_03FF;
            dat = $urandom;
            sel = 4'($urandom_range(15));
            we  = 1'($urandom_range(1));
            model_txn(adr, dat, sel, we, e_err, e_rdt);
            txn(0, adr, dat, sel, we, e_err, e_rdt, $sformatf("rand %0d", i));
        end

        // WAIT_CYCLES=0, cyc held across two reads
        txn(1, 32'h0, 32'h11111111, 4'hF, 1'b1, 1'b0, 32'h0, "w0 wr0");
        txn(1, 32'h4, 32'h22222222, 4'hF, 1'b1, 1'b0, 32'h0, "w0 wr4");
        wb_adr = 32'h0; wb_we = 1'b0; wb_sel = 4'hF; cyc[1] = 1'b1;
        @(posedge clk); #1;
        check("b2b ack1", 32'(ack[1]), 32'd1);
        check("b2b rdt1", rdt[1], 32'h11111111);
        wb_adr = 32'h4;
        @(posedge clk); #1;
        check("b2b gap", 32'(ack[1]), 32'd0);
        @(posedge clk); #1;
        check("b2b ack2", 32'(ack[1]), 32'd1);
        check("b2b rdt2", rdt[1], 32'h22222222);
        cyc[1] = 1'b0;
        @(posedge clk); #1;
        check("b2b after", 32'(ack[1]), 32'd0);

        // Abort during WAIT (WAIT_CYCLES=3)
        txn(2, 32'h20, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, 32'h0, "w3 wr20");
        txn(2, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0BADF00D, "w3 rd20");
        wb_adr = 32'h20; wb_dat = 32'h12345678; wb_sel = 4'hF; wb_we = 1'b1; cyc[2] = 1'b1;
        @(posedge clk); #1;
        cyc[2] = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
                seen = seen | ack[2] | err[2];
            end
            check("abort no response", 32'(seen), 32'd0);
        end
        txn(2, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0BADF00D, "abort rd20");

        // Reset during WAIT
        txn(2, 32'h30, 32'h55AA55AA, 4'hF, 1'b1, 1'b0, 32'h0BADF00D, "w3 wr30");
        txn(2, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 32'h55AA55AA, "w3 rd30");
        wb_adr = 32'h30; wb_dat = 32'h77777777; wb_sel = 4'hF; wb_we = 1'b1; cyc[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst ack", 32'(ack[2]), 32'd0);
        check("midrst err", 32'(err[2]), 32'd0);
        check("midrst rdt", rdt[2], 32'd0);
        check("midrst rdt inst0", rdt[0], 32'd0);
        cyc[2] = 1'b0;
        mdl_rdt = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        txn(2, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 32'h55AA55AA, "post-reset rd30");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
